if_id_redirect: RTL and testbench

Decode-side partner of the instruction fetch unit. It latches the fetched instruction and PC into the IF/ID pipeline register and resolves control transfers in the D stage. It drives `if_jump`, `next_pc` and `stall_pc` back to the fetch unit and tracks delay-slot membership. It sits between fetch and the D-stage register-file/forwarding logic, and is fed by the hazard unit.

---
 rtl/if_id_redirect_pkg.sv | 25 ++
 rtl/if_id_redirect_if.sv | 26 ++
 rtl/if_id_redirect_branch_cmp.sv | 24 ++
 rtl/if_id_redirect.sv | 75 +++++++
 tb/tb_if_id_redirect.sv | 134 +++++++++++++
 5 files changed

// File: rtl/if_id_redirect_pkg.sv
// if_id_redirect_pkg: MIPS decode constants and branch-kind encoding shared by the IF/ID redirect slice.
package if_id_redirect_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'h00003000;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_BLEZ = 6'b000110;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] FN_JR = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;
  typedef enum logic [2:0] {
    BK_NONE,
    BK_BEQ,
    BK_BNE,
    BK_BLEZ,
    BK_BGTZ,
    BK_BLTZ,
    BK_BGEZ
  } br_kind_e;
endpackage

// File: rtl/if_id_redirect_if.sv
// if_id_redirect_if: fetch/decode-side signals of the IF/ID redirect block; slave is the block, master drives F-stage inputs.
interface if_id_redirect_if;
  logic [31:0] instr_F;
  logic [31:0] PC_F;
  logic        hazard_stall;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall_pc;
  logic        if_jump;
  logic [31:0] next_pc;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        valid_D;
  logic        in_slot_D;
  logic        link_D;
  logic        bubble_E;
  modport master (
    output instr_F, PC_F, hazard_stall, rs_val, rt_val,
    input  stall_pc, if_jump, next_pc, instr_D, PC_D, PC8_D, valid_D, in_slot_D, link_D, bubble_E
  );
  modport slave (
    input  instr_F, PC_F, hazard_stall, rs_val, rt_val,
    output stall_pc, if_jump, next_pc, instr_D, PC_D, PC8_D, valid_D, in_slot_D, link_D, bubble_E
  );
endinterface

// File: rtl/if_id_redirect_branch_cmp.sv
// if_id_redirect_branch_cmp: combinational branch condition; zero-compare kinds exist only with IFID_ZERO_BRANCH_EN.
module if_id_redirect_branch_cmp
  import if_id_redirect_pkg::*;
(
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  input  br_kind_e    kind_i,
  output logic        taken_o
);
  logic eq, zt;
  assign eq = rs_val_i == rt_val_i;
`ifdef IFID_ZERO_BRANCH_EN
  logic neg, zero;
  assign neg = rs_val_i[31];
  assign zero = rs_val_i == 32'd0;
  assign zt = kind_i == BK_BLEZ ? (neg || zero) :
              kind_i == BK_BGTZ ? !(neg || zero) :
              kind_i == BK_BLTZ ? neg :
              kind_i == BK_BGEZ ? !neg : 1'b0;
`else
  assign zt = 1'b0;
`endif
  assign taken_o = kind_i == BK_BEQ ? eq : kind_i == BK_BNE ? !eq : zt;
endmodule

// File: rtl/if_id_redirect.sv
// if_id_redirect: IF/ID register plus D-stage branch/jump resolution with delay slots; IFID_ZERO_BRANCH_EN enables blez/bgtz/bltz/bgez.
module if_id_redirect
  import if_id_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input logic             clk,
  input logic             Reset,
  if_id_redirect_if.slave bus
);
  logic [31:0] instr_q, instr_d, pc_q, pc_d, pc4, br_tgt, j_tgt, tgt;
  logic        valid_q, valid_d, slot_q, slot_d;
  logic [5:0]  op, fn;
  logic        is_j, is_jr, is_link, br_taken, ctl, taken, jump;
  br_kind_e    kind, zk;
  assign op = instr_q[31:26];
  assign fn = instr_q[5:0];
  assign is_jr = op == OP_SPECIAL && (fn == FN_JR || fn == FN_JALR);
  assign is_j = op == OP_J || op == OP_JAL;
  assign is_link = op == OP_JAL || (op == OP_SPECIAL && fn == FN_JALR);
`ifdef IFID_ZERO_BRANCH_EN
  logic [4:0] rt;
  assign rt = instr_q[20:16];
  assign zk = op == OP_BLEZ ? BK_BLEZ :
              op == OP_BGTZ ? BK_BGTZ :
              op == OP_REGIMM && rt == RT_BLTZ ? BK_BLTZ :
              op == OP_REGIMM && rt == RT_BGEZ ? BK_BGEZ : BK_NONE;
`else
  assign zk = BK_NONE;
`endif
  assign kind = op == OP_BEQ ? BK_BEQ : op == OP_BNE ? BK_BNE : zk;
  if_id_redirect_branch_cmp branch_cmp (
    .rs_val_i(bus.rs_val),
    .rt_val_i(bus.rt_val),
    .kind_i  (kind),
    .taken_o (br_taken)
  );
  // Not-taken branches still count as control so their successor is marked as a slot.
  assign ctl = valid_q && (kind != BK_NONE || is_j || is_jr);
  assign taken = valid_q && (br_taken || is_j || is_jr);
  assign jump = taken && !bus.hazard_stall;
  assign pc4 = pc_q + 32'd4;
  assign br_tgt = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign j_tgt = {pc4[31:28], instr_q[25:0], 2'b00};
  assign tgt = is_jr ? bus.rs_val : is_j ? j_tgt : br_tgt;
  assign bus.if_jump = jump;
  assign bus.next_pc = jump ? tgt : pc4;
  assign bus.stall_pc = bus.hazard_stall;
  assign bus.bubble_E = bus.hazard_stall && valid_q;
  assign bus.link_D = valid_q && is_link;
  assign bus.instr_D = instr_q;
  assign bus.PC_D = pc_q;
  assign bus.PC8_D = pc_q + 32'd8;
  assign bus.valid_D = valid_q;
  assign bus.in_slot_D = slot_q;
  always_comb begin
    instr_d = bus.hazard_stall ? instr_q : bus.instr_F;
    pc_d = bus.hazard_stall ? pc_q : bus.PC_F;
    valid_d = bus.hazard_stall ? valid_q : 1'b1;
    slot_d = bus.hazard_stall ? slot_q : ctl;
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      instr_q <= 32'd0;
      pc_q <= RESET_PC;
      valid_q <= 1'b0;
      slot_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
      slot_q <= slot_d;
    end
  end
endmodule

// File: tb/tb_if_id_redirect.sv
// tb_if_id_redirect: scoreboard bench; per-cycle expectations are queued with the stimulus and drained against the DUT.
module tb_if_id_redirect;
  import if_id_redirect_pkg::*;
`ifdef IFID_ZERO_BRANCH_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  if_id_redirect_if bus ();
  if_id_redirect dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );
  function automatic logic [31:0] obs(string tag);
    case (tag)
      "instr":  return bus.instr_D;
      "pc":     return bus.PC_D;
      "pc8":    return bus.PC8_D;
      "valid":  return {31'd0, bus.valid_D};
      "slot":   return {31'd0, bus.in_slot_D};
      "link":   return {31'd0, bus.link_D};
      "jump":   return {31'd0, bus.if_jump};
      "npc":    return bus.next_pc;
      "bubble": return {31'd0, bus.bubble_E};
      "stallpc": return {31'd0, bus.stall_pc};
      default:  return 32'hxxxxxxxx;
    endcase
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask
  task automatic want(string tag, logic [31:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic cyc(logic r, logic [31:0] i, logic [31:0] p, logic st, logic [31:0] rs, logic [31:0] rt);
    exp_t e;
    Reset = r;
    bus.instr_F = i;
    bus.PC_F = p;
    bus.hazard_stall = st;
    bus.rs_val = rs;
    bus.rt_val = rt;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.tag), e.val);
    end
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.instr_F = 32'h1000FFFF;
    bus.PC_F = 32'h0;
    bus.hazard_stall = 1'b0;
    bus.rs_val = 32'h0;
    bus.rt_val = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state, stall requested while D is empty
    want("instr", 32'h0); want("pc", 32'h3000); want("valid", 0); want("jump", 0);
    want("slot", 0); want("link", 0); want("bubble", 0); want("stallpc", 1); want("npc", 32'h3004);
    cyc(0, 32'h0, 32'h3000, 1, 0, 0);
    want("valid", 0); want("pc", 32'h3000); want("stallpc", 0);
    cyc(0, 32'h0, 32'h3000, 0, 0, 0);
    want("valid", 1); want("instr", 32'h0); want("slot", 0); want("jump", 0); want("npc", 32'h3004); want("pc8", 32'h3008);
    cyc(0, 32'h10220003, 32'h3004, 0, 0, 0);
    // beq taken
    want("instr", 32'h10220003); want("jump", 1); want("npc", 32'h3014); want("slot", 0); want("link", 0);
    cyc(0, 32'h0, 32'h3008, 0, 5, 5);
    want("slot", 1); want("pc", 32'h3008); want("jump", 0); want("valid", 1);
    cyc(0, 32'h14220005, 32'h3014, 0, 0, 0);
    // bne not taken, successor still a slot
    want("jump", 0); want("npc", 32'h3018); want("slot", 0);
    cyc(0, 32'h0, 32'h3018, 0, 7, 7);
    want("slot", 1);
    cyc(0, 32'h0C000C00, 32'h301C, 0, 0, 0);
    // jal followed by jr in its slot
    want("jump", 1); want("npc", 32'h3000); want("link", 1); want("pc8", 32'h3024);
    cyc(0, 32'h01200008, 32'h3020, 0, 32'h3abc, 0);
    want("jump", 1); want("npc", 32'h3abc); want("slot", 1); want("link", 0);
    cyc(0, 32'h0, 32'h3000, 0, 32'h3abc, 0);
    want("slot", 1); want("jump", 0);
    cyc(0, 32'h00600009, 32'h3abc, 0, 0, 0);
    // jalr keeps unaligned low bits
    want("jump", 1); want("npc", 32'h3ab1); want("link", 1); want("pc8", 32'h3ac4);
    cyc(0, 32'h10220003, 32'h3ac0, 0, 32'h3ab1, 0);
    // stalled beq
    want("jump", 0); want("bubble", 1); want("stallpc", 1); want("instr", 32'h10220003); want("slot", 1);
    cyc(0, 32'hDEADBEEF, 32'h3ac4, 1, 5, 6);
    want("jump", 0); want("bubble", 1); want("instr", 32'h10220003); want("pc", 32'h3ac0); want("npc", 32'h3ac4);
    cyc(0, 32'hDEADBEEF, 32'h3ac4, 1, 9, 9);
    want("jump", 1); want("npc", 32'h3ad0); want("bubble", 0);
    cyc(0, 32'h0, 32'h3ac4, 0, 9, 9);
    want("instr", 32'h0); want("pc", 32'h3ac4); want("slot", 1);
    cyc(0, 32'h0401FFFE, 32'h3ad0, 0, 0, 0);
    // bgez with negative rs, then bgez in its slot with rs=0
    want("instr", 32'h0401FFFE); want("jump", 0); want("npc", 32'h3ad4);
    cyc(0, 32'h0401FFFE, 32'h3ad4, 0, 32'h80000000, 0);
    want("slot", {31'd0, ZB}); want("jump", {31'd0, ZB}); want("npc", ZB ? 32'h3ad0 : 32'h3ad8);
    cyc(0, 32'hFC000000, 32'h3ad8, 0, 0, 0);
    // unknown opcode
    want("slot", {31'd0, ZB}); want("jump", 0); want("npc", 32'h3adc);
    cyc(0, 32'h10220003, 32'h3adc, 0, 0, 0);
    want("slot", 0); want("jump", 1); want("npc", 32'h3aec);
    cyc(0, 32'h10220003, 32'h3ae0, 0, 1, 1);
    // reset beats stall while a branch is in D
    want("slot", 1); want("jump", 0); want("bubble", 1);
    cyc(1, 32'h10220003, 32'h3ae4, 1, 1, 1);
    want("valid", 0); want("instr", 32'h0); want("pc", 32'h3000); want("slot", 0);
    want("jump", 0); want("bubble", 0); want("npc", 32'h3004);
    cyc(0, 32'h0, 32'h3000, 0, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
